// File: rtl/piso_bit_serializer_if.sv
// Parallel-load handshake plus serial bit stream shared by the serializer and its neighbours.
interface piso_bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             x_out;
  logic             x_valid;
  logic             x_last;

  modport master (
    output load_valid, load_data,
    input  load_ready, x_out, x_valid, x_last
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, x_out, x_valid, x_last
  );
endinterface

// File: rtl/piso_bit_serializer.sv
// Parallel-in serial-out shifter with a one-word holding buffer for gapless back-to-back words.
module piso_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  piso_bit_serializer_if.slave    bus,
  output logic                    busy,
  output logic [7:0]              word_count
);

  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             xfer;
  logic             last_bit;
  logic [WIDTH-1:0] sh_next;

  assign bus.load_ready = !hold_full_q;
  assign xfer           = bus.load_valid && !hold_full_q;
  assign last_bit       = (state_q == SHIFT) && (idx_q == IW'(WIDTH - 1));
  assign sh_next        = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

  assign bus.x_valid = (state_q == SHIFT);
  assign bus.x_out   = (state_q == SHIFT) && (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]);
  assign bus.x_last  = last_bit;
  assign busy        = (state_q == SHIFT) || hold_full_q;
  assign word_count  = cnt_q;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          sh_d    = bus.load_data;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // Refill on the last-bit edge so the next word follows with no gap.
          cnt_d = cnt_q + 8'd1;
          idx_d = '0;
          if (hold_full_q) begin
            sh_d        = hold_q;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            sh_d = bus.load_data;
          end else begin
            sh_d    = '0;
            state_d = IDLE;
          end
        end else begin
          sh_d  = sh_next;
          idx_d = idx_q + IW'(1);
          if (xfer) begin
            hold_d      = bus.load_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
